scan_schedule_ctrl: RTL and testbench

SCAN polar-decoder tree-traversal controller. It walks the depth-first SCAN schedule for an N-bit code over ITER iterations. Each step it issues one operation code (`u_type_r`) and one node size (`layer_r`), which the downstream address generator turns into alpha/beta memory read indices. It sits directly upstream of the address generator and the PE array: every accepted step is one f/g/combine/leaf operation.

---
 rtl/scan_schedule_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_scan_schedule_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/scan_schedule_ctrl.sv
// -----------------------------------------------------------------------------
// scan_schedule_ctrl
//
// Tree-traversal controller for a SCAN polar decoder. Walks the depth-first
// SCAN schedule of an N-bit code for up to ITER iterations per codeword and
// presents one operation per cycle to the downstream address generator / PE
// array through a valid/ready handshake.
//
// Each presented step is an (operation code, node size) pair:
//   TYPE1  (4'b0000) left child, f    layer_r = 2^k
//   TYPE2  (4'b0001) right child, g   layer_r = 2^k
//   BOTTOM (4'b0010) leaf pair        layer_r = 2
//   TYPE3  (4'b0011) combine          layer_r = 2^(k-1)
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       pulse, begins a codeword (honoured only when idle)
//   early_stop  level, sampled only when the root combine is accepted
//   step_ready  downstream accepts the presented step
//   step_valid  a step is presented
//   u_type_r    operation code of the presented step
//   layer_r     node size of the presented step (zero-extended to 11 bits)
//   leaf_idx    leaf-pair index, meaningful on BOTTOM steps
//   iter_idx    current iteration, 0..ITER-1
//   busy        codeword in progress
//   done        one-cycle pulse when the codeword has finished
// -----------------------------------------------------------------------------
module scan_schedule_ctrl #(
    parameter int N    = 1024,
    parameter int ITER = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    early_stop,
    input  logic                    step_ready,
    output logic                    step_valid,
    output logic [3:0]              u_type_r,
    output logic [10:0]             layer_r,
    output logic [$clog2(N)-2:0]    leaf_idx,
    output logic [3:0]              iter_idx,
    output logic                    busy,
    output logic                    done
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam int         LOGN      = $clog2(N);
    localparam int         LEAF_W    = LOGN - 1;
    localparam int         PH_LEVELS = LOGN - 1;      // levels 2..LOGN carry a phase
    localparam logic [3:0] K_TOP     = 4'(LOGN);
    localparam logic [3:0] ITER_LAST = 4'(ITER - 1);

    localparam logic [3:0] UT_TYPE1  = 4'b0000;
    localparam logic [3:0] UT_TYPE2  = 4'b0001;
    localparam logic [3:0] UT_BOTTOM = 4'b0010;
    localparam logic [3:0] UT_TYPE3  = 4'b0011;

    // Phase of a node: which of its three operations is due next.
    localparam logic [1:0] PH_LEFT   = 2'd0;
    localparam logic [1:0] PH_RIGHT  = 2'd1;
    localparam logic [1:0] PH_COMB   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                     state_reg;
    logic [3:0]                 k_reg;          // current level, node size 2^k
    logic [LEAF_W-1:0]          leaf_reg;
    logic [3:0]                 iter_reg;
    logic                       busy_reg;
    logic                       done_reg;

    // Per-level phases, level gi stored at bits [2*(gi-2) +: 2].
    logic [2*PH_LEVELS-1:0]     ph_flat;

    logic [1:0]                 cur_ph;
    logic                       accept;
    logic                       start_ok;
    logic                       at_root;
    logic                       is_leaf_level;

    assign start_ok      = (state_reg == ST_IDLE) && start;
    assign accept        = step_valid && step_ready;
    assign at_root       = (k_reg == K_TOP);
    assign is_leaf_level = (k_reg == 4'd1);

    // -------------------------------------------------------------------------
    // Phase of the current level. Level 1 has no phase (it is always a leaf
    // pair), so the mux simply yields zero there.
    // -------------------------------------------------------------------------
    always_comb begin
        cur_ph = PH_LEFT;
        for (int i = 2; i <= LOGN; i++) begin
            if (k_reg == 4'(i)) begin
                cur_ph = ph_flat[2*(i-2) +: 2];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Step decode. Everything here is a function of registered state only, so
    // the step presented downstream cannot change while step_ready is low.
    // -------------------------------------------------------------------------
    always_comb begin
        step_valid = 1'b0;
        u_type_r   = UT_TYPE1;
        layer_r    = 11'd0;
        if (state_reg == ST_RUN) begin
            step_valid = 1'b1;
            if (is_leaf_level) begin
                u_type_r = UT_BOTTOM;
                layer_r  = 11'd2;
            end else begin
                unique case (cur_ph)
                    PH_LEFT: begin
                        u_type_r = UT_TYPE1;
                        layer_r  = 11'(1) << k_reg;
                    end
                    PH_RIGHT: begin
                        u_type_r = UT_TYPE2;
                        layer_r  = 11'(1) << k_reg;
                    end
                    default: begin
                        // Phase 3 never occurs; it decodes as a combine.
                        u_type_r = UT_TYPE3;
                        layer_r  = 11'(1) << (k_reg - 4'd1);
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM: traversal level, leaf / iteration counters, busy and done.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            k_reg     <= K_TOP;
            leaf_reg  <= '0;
            iter_reg  <= 4'd0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    done_reg <= 1'b0;
                    if (start_ok) begin
                        state_reg <= ST_RUN;
                        k_reg     <= K_TOP;
                        leaf_reg  <= '0;
                        iter_reg  <= 4'd0;
                        busy_reg  <= 1'b1;
                    end
                end

                ST_RUN: begin
                    if (accept) begin
                        unique case (u_type_r)
                            UT_BOTTOM: begin
                                // Counter width is log2(N/2), so it wraps
                                // from N/2-1 to 0 by itself.
                                leaf_reg <= leaf_reg + 1'b1;
                                k_reg    <= k_reg + 4'd1;
                            end
                            UT_TYPE1, UT_TYPE2: begin
                                k_reg <= k_reg - 4'd1;
                            end
                            default: begin
                                if (!at_root) begin
                                    k_reg <= k_reg + 4'd1;
                                end else if ((iter_reg == ITER_LAST) || early_stop) begin
                                    // Root combine of the final iteration.
                                    state_reg <= ST_FIN;
                                    busy_reg  <= 1'b0;
                                    done_reg  <= 1'b1;
                                end else begin
                                    // Iteration boundary: restart at the root.
                                    iter_reg <= iter_reg + 4'd1;
                                    leaf_reg <= '0;
                                end
                            end
                        endcase
                    end
                end

                ST_FIN: begin
                    state_reg <= ST_IDLE;
                    done_reg  <= 1'b0;
                end

                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Per-level phase registers.
    //
    // A level advances its own phase when its node issues f or g, and clears
    // when it combines. When a node descends (f or g), the child one level
    // below starts afresh, so that child's phase is cleared as well.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 2; gi <= LOGN; gi++) begin : g_ph
            logic [1:0] ph_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ph_reg <= PH_LEFT;
                end else if (start_ok) begin
                    ph_reg <= PH_LEFT;
                end else if (accept) begin
                    if (k_reg == 4'(gi)) begin
                        unique case (u_type_r)
                            UT_TYPE1: ph_reg <= PH_RIGHT;
                            UT_TYPE2: ph_reg <= PH_COMB;
                            UT_TYPE3: ph_reg <= PH_LEFT;
                            default:  ph_reg <= ph_reg;
                        endcase
                    end else if ((k_reg == 4'(gi + 1)) &&
                                 ((u_type_r == UT_TYPE1) || (u_type_r == UT_TYPE2))) begin
                        ph_reg <= PH_LEFT;
                    end
                end
            end

            assign ph_flat[2*(gi-2) +: 2] = ph_reg;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign leaf_idx = leaf_reg;
    assign iter_idx = iter_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_scan_schedule_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scan_schedule_ctrl
//
// Drives scan_schedule_ctrl (N=16, ITER=4) with randomized ready / early_stop /
// start stimulus and compares every accepted step against a schedule built
// from the SCAN leaf-to-leaf transition rule: between leaf pair j-1 and j the
// tree climbs tz(j) combines (tz = trailing zeros of j), issues one g at the
// node of size 2^(tz+2), then descends with f down to size 4.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_scan_schedule_ctrl;

    localparam int N    = 16;
    localparam int ITER = 4;
    localparam int LOGN = $clog2(N);

    localparam logic [3:0] T1  = 4'b0000;
    localparam logic [3:0] T2  = 4'b0001;
    localparam logic [3:0] BOT = 4'b0010;
    localparam logic [3:0] T3  = 4'b0011;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic                early_stop;
    logic                step_ready;
    logic                step_valid;
    logic [3:0]          u_type_r;
    logic [10:0]         layer_r;
    logic [LOGN-2:0]     leaf_idx;
    logic [3:0]          iter_idx;
    logic                busy;
    logic                done;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0]  ut;
        logic [10:0] lay;
        int          leaf;
        int          it;
        bit          last;   // root combine ending an iteration
    } step_t;

    step_t exp_q[$];

    scan_schedule_ctrl #(.N(N), .ITER(ITER)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .early_stop (early_stop),
        .step_ready (step_ready),
        .step_valid (step_valid),
        .u_type_r   (u_type_r),
        .layer_r    (layer_r),
        .leaf_idx   (leaf_idx),
        .iter_idx   (iter_idx),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void push(input logic [3:0] ut, input int size, input int leaf,
                                 input int it, input bit last);
        step_t s;
        s.ut   = ut;
        s.lay  = 11'(size);
        s.leaf = leaf;
        s.it   = it;
        s.last = last;
        exp_q.push_back(s);
    endfunction

    // Expected accepted-step sequence for n_it iterations.
    task automatic build(input int n_it);
        int tz;
        exp_q.delete();
        for (int it = 0; it < n_it; it++) begin
            for (int j = 0; j < N/2; j++) begin
                if (j == 0) begin
                    for (int s = LOGN; s >= 2; s--) push(T1, 1 << s, 0, it, 1'b0);
                end else begin
                    tz = 0;
                    while (((j >> tz) & 1) == 0) tz++;
                    for (int i = 0; i < tz; i++) push(T3, 1 << (i+1), 0, it, 1'b0);
                    push(T2, 1 << (tz+2), 0, it, 1'b0);
                    for (int s = tz+1; s >= 2; s--) push(T1, 1 << s, 0, it, 1'b0);
                end
                push(BOT, 2, j, it, 1'b0);
            end
            for (int i = 0; i < LOGN-1; i++) push(T3, 1 << (i+1), 0, it, i == LOGN-2);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, step_valid, 1'b0);
        chk({tag, "_busy"},  busy,       1'b0);
        chk({tag, "_done"},  done,       1'b0);
        chk({tag, "_type"},  u_type_r,   4'd0);
        chk({tag, "_layer"}, layer_r,    11'd0);
        chk({tag, "_leaf"},  leaf_idx,   '0);
        chk({tag, "_iter"},  iter_idx,   4'd0);
    endtask

    // One codeword. stop_it: iteration whose root combine sees early_stop=1
    // (>= ITER means never). abort_at >= 0 pulls rst_n after that many steps.
    task automatic run_cw(input int stop_it, input bit rnd_ready, input bit poke,
                          input int abort_at);
        int          n_it, idx, cyc, limit;
        bit          stalled;
        logic [3:0]  p_ut;
        logic [10:0] p_lay;
        logic [LOGN-2:0] p_leaf;
        logic [3:0]  p_iter;

        n_it = (stop_it < ITER) ? stop_it + 1 : ITER;
        build(n_it);

        @(negedge clk);
        start = 1'b1; step_ready = 1'b1; early_stop = 1'b0;
        @(negedge clk);
        start = 1'b0;

        idx = 0; cyc = 0; stalled = 1'b0; limit = 4 * exp_q.size() + 20;
        p_ut = '0; p_lay = '0; p_leaf = '0; p_iter = '0;

        while (idx < exp_q.size() && cyc < limit) begin
            if (abort_at >= 0 && idx >= abort_at) begin
                rst_n = 1'b0; start = 1'b0;
                #1;
                chk_idle("rst_mid");
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                chk("post_rst_valid", step_valid, 1'b0);
                $display("[TB] codeword aborted by reset after %0d steps", idx);
                return;
            end

            chk("valid", step_valid, 1'b1);
            chk("busy",  busy,       1'b1);
            if (stalled) begin
                chk("hold_type",  u_type_r, p_ut);
                chk("hold_layer", layer_r,  p_lay);
                chk("hold_leaf",  leaf_idx, p_leaf);
                chk("hold_iter",  iter_idx, p_iter);
            end

            step_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            early_stop = exp_q[idx].last ? (exp_q[idx].it == stop_it)
                                         : 1'($urandom_range(0, 1));
            start      = poke ? ($urandom_range(0, 9) == 0) : 1'b0;

            if (step_ready) begin
                chk("type",  u_type_r, exp_q[idx].ut);
                chk("layer", layer_r,  exp_q[idx].lay);
                chk("iter",  iter_idx, exp_q[idx].it);
                if (exp_q[idx].ut == BOT) chk("leaf", leaf_idx, exp_q[idx].leaf);
                idx++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                p_ut = u_type_r; p_lay = layer_r; p_leaf = leaf_idx; p_iter = iter_idx;
            end
            @(negedge clk);
            cyc++;
        end

        chk("timeout", idx, exp_q.size());
        start = 1'b0; early_stop = 1'b0; step_ready = 1'b1;

        chk("fin_done",  done,       1'b1);
        chk("fin_busy",  busy,       1'b0);
        chk("fin_valid", step_valid, 1'b0);
        chk("fin_iter",  iter_idx,   n_it - 1);
        chk("fin_type",  u_type_r,   4'd0);
        chk("fin_layer", layer_r,    11'd0);
        @(negedge clk);
        chk("idle_done",  done,       1'b0);
        chk("idle_valid", step_valid, 1'b0);
        $display("[TB] codeword stop_it=%0d rnd_ready=%0d poke=%0d steps=%0d cycles=%0d",
                 stop_it, rnd_ready, poke, idx, cyc);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; step_ready = 1'b0; early_stop = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("idle");

        run_cw(99, 1'b0, 1'b0, -1);   // full run, no stalls
        run_cw(99, 1'b1, 1'b0, -1);   // full run, random stalls
        run_cw(1,  1'b1, 1'b0, -1);   // early stop after iteration 1
        run_cw(0,  1'b0, 1'b1, -1);   // early stop after iteration 0, start pokes
        run_cw(99, 1'b1, 1'b1, -1);   // stalls and start pokes
        run_cw(99, 1'b0, 1'b0, 50);   // reset mid-run
        run_cw(2,  1'b1, 1'b0, -1);   // fresh codeword after reset

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
